// File: rtl/frame_sched.sv
// Frame builder scheduler: round-robin grant of one channel FIFO, then
// M header cycles, N payload reads and GAP idle cycles per frame.
//
//   state  | meaning
//   IDLE   | waiting for any prg_full with tx_ready high
//   HDR    | header words 0..M-1 presented, h_en high
//   DATA   | N payload reads from the granted FIFO
//   GAP    | inter-frame idle, GAP cycles
module frame_sched #(
  parameter int NCH = 4,
  parameter int M   = 4,
  parameter int N   = 4096,
  parameter int GAP = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] prg_full,
  input  logic           tx_ready,
  output logic [NCH-1:0] fifo_rd,
  output logic           h_en,
  output logic [1:0]     Header_Address,
  output logic [1:0]     ch_sel,
  output logic           fr_start,
  output logic           busy,
  output logic [15:0]    frame_cnt
);

  localparam int WW = 13;
  localparam logic [1:0]    HDR_LAST  = 2'(M - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(N - 1);
  localparam logic [15:0]   GAP_LOAD  = 16'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [1:0]     last_grant_q, last_grant_d;
  logic [1:0]     ch_sel_q, ch_sel_d;
  logic [1:0]     hdr_addr_q, hdr_addr_d;
  logic [WW-1:0]  word_cnt_q, word_cnt_d;
  logic [15:0]    gap_cnt_q, gap_cnt_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [NCH-1:0] fifo_rd_q, fifo_rd_d;
  logic           h_en_q, h_en_d;
  logic           fr_start_q, fr_start_d;
  logic           busy_q, busy_d;

  logic           grant_vld;
  logic [1:0]     grant_ch;
  logic [2:0]     rr_sum;
  logic [1:0]     rr_cand;
  logic           go;

  // Round-robin search starting one past the previous grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = last_grant_q;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int i = 1; i <= NCH; i++) begin
      rr_sum  = {1'b0, last_grant_q} + 3'(i);
      rr_cand = (rr_sum >= 3'(NCH)) ? 2'(rr_sum - 3'(NCH)) : rr_sum[1:0];
      if (!grant_vld && prg_full[rr_cand]) begin
        grant_vld = 1'b1;
        grant_ch  = rr_cand;
      end
    end
  end

  assign go = (state_q == S_IDLE) && grant_vld && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 2'(NCH - 1);
      ch_sel_q     <= '0;
      hdr_addr_q   <= '0;
      word_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      fifo_rd_q    <= '0;
      h_en_q       <= 1'b0;
      fr_start_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ch_sel_q     <= ch_sel_d;
      hdr_addr_q   <= hdr_addr_d;
      word_cnt_q   <= word_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      fifo_rd_q    <= fifo_rd_d;
      h_en_q       <= h_en_d;
      fr_start_q   <= fr_start_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_HDR;
      S_HDR:   if (hdr_addr_q == HDR_LAST) state_d = S_DATA;
      S_DATA:  if (word_cnt_q == WORD_LAST) state_d = S_GAP;
      S_GAP:   if (gap_cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes from a flop.
  always_comb begin
    last_grant_d = last_grant_q;
    ch_sel_d     = ch_sel_q;
    if (go) begin
      last_grant_d = grant_ch;
      ch_sel_d     = grant_ch;
    end

    hdr_addr_d = '0;
    if (state_q == S_HDR && state_d == S_HDR) hdr_addr_d = hdr_addr_q + 2'd1;

    word_cnt_d = '0;
    if (state_q == S_DATA && state_d == S_DATA) word_cnt_d = word_cnt_q + WW'(1);

    gap_cnt_d = '0;
    if (state_d == S_GAP) gap_cnt_d = (state_q == S_GAP) ? gap_cnt_q - 16'd1 : GAP_LOAD;

    frame_cnt_d = frame_cnt_q;
    if (state_q == S_DATA && state_d == S_GAP) frame_cnt_d = frame_cnt_q + 16'd1;

    fifo_rd_d = '0;
    if (state_d == S_DATA) fifo_rd_d[ch_sel_d] = 1'b1;

    h_en_d     = (state_d == S_HDR);
    fr_start_d = go;
    busy_d     = (state_d != S_IDLE);
  end

  assign fifo_rd        = fifo_rd_q;
  assign h_en           = h_en_q;
  assign Header_Address = hdr_addr_q;
  assign ch_sel         = ch_sel_q;
  assign fr_start       = fr_start_q;
  assign busy           = busy_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: a per-frame timeline model (cycles since grant)
// plus round-robin bookkeeping predicts every output on every cycle.
module tb_frame_sched;
  localparam int NCH = 4;
  localparam int M   = 4;
  localparam int N   = 4096;
  localparam int GAP = 12;
  localparam int PER = M + N + GAP + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] prg_full;
  logic           tx_ready;
  logic [NCH-1:0] fifo_rd;
  logic           h_en;
  logic [1:0]     Header_Address;
  logic [1:0]     ch_sel;
  logic           fr_start;
  logic           busy;
  logic [15:0]    frame_cnt;

  frame_sched #(.NCH(NCH), .M(M), .N(N), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .prg_full(prg_full), .tx_ready(tx_ready),
    .fifo_rd(fifo_rd), .h_en(h_en), .Header_Address(Header_Address),
    .ch_sel(ch_sel), .fr_start(fr_start), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // reference model: t = cycles since the grant edge (0 = idle)
  int t = 0;
  int ch = 0;
  int last = NCH - 1;
  int fcnt = 0;
  bit ch_chk = 1'b1;
  int reads = 0;
  int fs_cyc[$];
  int fs_ch[$];

  function automatic int rr_pick(input int from, input logic [3:0] req);
    int c;
    for (int d = 1; d <= NCH; d++) begin
      c = (from + d) % NCH;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NCH-1:0] e_rd;
    logic           e_hen;
    logic [1:0]     e_addr;
    @(posedge clk);
    cyc++;
    if (rst) begin
      t = 0; ch = 0; last = NCH - 1; fcnt = 0; ch_chk = 1'b1;
    end else if (t == 0) begin
      if (prg_full != '0 && tx_ready) begin
        ch = rr_pick(last, prg_full);
        last = ch;
        t = 1;
      end
    end else begin
      t++;
      if (t == M + N + 1) fcnt = (fcnt + 1) % 65536;
      if (t > M + N + GAP) begin
        t = 0;
        ch_chk = 1'b0;
      end
    end
    @(negedge clk);
    e_rd   = (t > M && t <= M + N) ? 4'(1 << ch) : 4'b0;
    e_hen  = (t >= 1 && t <= M);
    e_addr = e_hen ? 2'(t - 1) : 2'd0;
    chk("outputs", {fifo_rd, h_en, Header_Address, fr_start, busy, frame_cnt},
        {e_rd, e_hen, e_addr, (t == 1), (t != 0), 16'(fcnt)});
    if (t != 0 || ch_chk) chk("ch_sel", 32'(ch_sel), ch);
    if (fifo_rd != '0) reads++;
    if (fr_start) begin
      fs_cyc.push_back(cyc);
      fs_ch.push_back(int'(ch_sel));
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_frame(input bit rnd);
    int b;
    b = 0;
    while (t != 0 && b < 2 * PER) begin
      if (rnd) begin
        prg_full = 4'($urandom);
        tx_ready = 1'($urandom);
      end
      tick();
      b++;
    end
    if (t != 0) chk("frame_bound", 32'(t), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; prg_full = '0; tx_ready = 1'b0;
    @(negedge clk);
    run(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_rd", 32'(fifo_rd), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);

    // tx_ready held low: no grant for 50 cycles, then grant on the rising edge
    rst = 1'b0; prg_full = 4'b0100; tx_ready = 1'b0;
    run(50);
    chk("txr_low_busy", 32'(busy), 0);
    tx_ready = 1'b1;
    tick();
    chk("txr_grant_ch", 32'(ch_sel), 2);
    chk("txr_fr_start", 32'(fr_start), 1);

    // random inputs mid-frame are ignored; abort with rst at DATA word 100
    for (int i = 0; i < M + 100; i++) begin
      prg_full = 4'($urandom);
      tx_ready = 1'($urandom);
      tick();
    end
    chk("word100_rd", 32'(fifo_rd), 32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rd", 32'(fifo_rd), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_frame_cnt", 32'(frame_cnt), 0);

    // next grant goes to channel 0; granted request dropped during HDR
    prg_full = 4'b1001; tx_ready = 1'b1;
    tick();
    chk("post_rst_grant", 32'(ch_sel), 0);
    reads = 0;
    run(2);
    prg_full = 4'b1000; tx_ready = 1'b0;
    run_frame(1'b0);
    chk("drop_reads", reads, N);
    chk("drop_frame_cnt", 32'(frame_cnt), 1);

    // single channel 0 frame after reset
    rst = 1'b1; prg_full = '0;
    tick();
    rst = 1'b0; prg_full = 4'b0001; tx_ready = 1'b1; reads = 0;
    tick();
    chk("c0_fr_start", 32'(fr_start), 1);
    chk("c0_hdr_addr0", {h_en, Header_Address}, 3'b100);
    for (int i = 1; i < M; i++) begin
      tick();
      chk("c0_hdr_addr", {h_en, Header_Address}, {1'b1, 2'(i)});
    end
    run_frame(1'b0);
    prg_full = '0;
    chk("c0_reads", reads, N);
    chk("c0_frame_cnt", 32'(frame_cnt), 1);

    // all channels requesting: order 0,1,2,3,0 at the frame period
    rst = 1'b1;
    tick();
    rst = 1'b0; prg_full = 4'b1111; tx_ready = 1'b1;
    fs_cyc.delete(); fs_ch.delete();
    run(4 * PER + 1);
    prg_full = '0;
    run_frame(1'b0);
    chk("rr_count", fs_ch.size(), 5);
    if (fs_ch.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", fs_ch[i], exp_order[i]);
      for (int i = 1; i < 5; i++) chk("rr_spacing", fs_cyc[i] - fs_cyc[i-1], PER);
    end

    // random request patterns and idle stretches
    repeat (3) begin
      repeat ($urandom_range(0, 4)) begin
        prg_full = 4'($urandom);
        tx_ready = 1'($urandom);
        tick();
      end
      run_frame(1'b1);
      prg_full = 4'($urandom_range(1, 15));
      tx_ready = 1'b1;
      e = rr_pick(last, prg_full);
      tick();
      chk("rand_grant", 32'(ch_sel), e);
      run_frame(1'b1);
    end

    // frame counter wrap
    prg_full = '0; tx_ready = 1'b0;
    tick();
    force dut.frame_cnt_q = 16'hFFFF;
    fcnt = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("preload_frame_cnt", 32'(frame_cnt), 32'hFFFF);
    prg_full = 4'b0010; tx_ready = 1'b1;
    tick();
    prg_full = '0;
    run_frame(1'b0);
    chk("wrap_frame_cnt", 32'(frame_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter NCH, default 4: number of channel FIFOs sharing the frame builder.
REQ-002 SHALL have parameter M, default 4: header words per frame.
REQ-003 SHALL have parameter N, default 4096: payload words per frame.
REQ-004 SHALL have parameter GAP, default 12: idle cycles between frames.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port prg_full, input, NCH bits: per-channel FIFO programmable-full, used as the frame request.
REQ-008 SHALL have port tx_ready, input, 1 bit: the Ethernet module can accept a new frame.
REQ-009 SHALL have port fifo_rd, output, NCH bits: one-hot read enable to the granted FIFO.
REQ-010 SHALL have port h_en, output, 1 bit: header registers enabled.
REQ-011 SHALL have port Header_Address, output, 2 bits: header word index.
REQ-012 SHALL have port ch_sel, output, 2 bits: granted channel, driving the payload mux.
REQ-013 SHALL have port fr_start, output, 1 bit: one-cycle pulse on the first header cycle.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port frame_cnt, output, 16 bits: count of completed frames.

Function
REQ-016 SHALL implement states IDLE, HDR, DATA and GAP, all with registered outputs.
REQ-017 In IDLE, when prg_full is nonzero and tx_ready is 1, SHALL grant one channel and enter HDR on the next edge.
- Otherwise SHALL remain in IDLE.
REQ-018 Arbitration SHALL be round-robin.
- Search starts at last_grant+1 and wraps modulo NCH.
- last_grant updates on each grant.
REQ-019 ch_sel SHALL be latched at the grant and held constant until the return to IDLE.
- prg_full changes after the grant SHALL NOT affect the current frame.
REQ-020 HDR SHALL last exactly M cycles.
- h_en is 1 throughout.
- Header_Address is 0 on the first cycle and increments by 1 each cycle, reaching M-1.
- fr_start is 1 only on the first HDR cycle.
REQ-021 After the HDR cycle with Header_Address==M-1, SHALL enter DATA.
- h_en goes to 0.
- Header_Address returns to 0.
REQ-022 DATA SHALL last exactly N cycles.
- fifo_rd[ch_sel] is 1 on every DATA cycle; all other fifo_rd bits are 0.
- An internal 13-bit word counter runs 0..N-1.
REQ-023 On the last DATA cycle, SHALL enter GAP and increment frame_cnt.
- frame_cnt wraps from 16'hFFFF to 0.
REQ-024 GAP SHALL last exactly GAP cycles with fifo_rd, h_en and fr_start all 0, then return to IDLE.
REQ-025 tx_ready SHALL be sampled only in IDLE.
- Deassertion during HDR, DATA or GAP is ignored.
REQ-026 Frame period from grant to the next possible grant SHALL be M+N+GAP+1 cycles.
REQ-027 fifo_rd SHALL never have more than one bit set.
- fifo_rd SHALL be 0 outside DATA.
REQ-028 When only one channel requests, that channel SHALL be granted regardless of last_grant.

Reset
REQ-029 While rst is 1 at a clock edge, SHALL load, on that edge:
- state to IDLE;
- fifo_rd, h_en, Header_Address, fr_start, busy and ch_sel to 0;
- frame_cnt to 0;
- the word and gap counters to 0;
- last_grant to NCH-1, so channel 0 has first priority.
REQ-030 Reset asserted mid-frame SHALL abort the frame.
- fifo_rd is 0 from the edge that samples rst.
- frame_cnt is not incremented for the aborted frame.
REQ-031 After rst is released, SHALL NOT grant until the first edge at which IDLE conditions hold.

Verification
REQ-032 Bench SHALL cover: reset, then prg_full=4'b0001, tx_ready=1 -> fr_start one cycle later.
- Header_Address 0,1,2,3 with h_en=1.
- Then fifo_rd=4'b0001 for exactly 4096 cycles.
- frame_cnt=1.
REQ-033 Bench SHALL cover: prg_full=4'b1111 held -> grants in order 0,1,2,3,0.
- Each fr_start is 4113 cycles apart.
REQ-034 Bench SHALL cover: prg_full=4'b0100 with tx_ready=0 for 50 cycles, then tx_ready=1 -> no activity for the 50 cycles.
- Then a grant of ch_sel=2 on the edge after tx_ready rises.
REQ-035 Bench SHALL cover: rst pulsed at DATA word 100 -> fifo_rd=0 and busy=0 on the next edge.
- frame_cnt stays at its prior value.
- The next grant goes to channel 0.
REQ-036 Bench SHALL cover: frame_cnt preloaded or run to 16'hFFFF, then one more frame -> frame_cnt=0.
REQ-037 Bench SHALL cover: prg_full of the granted channel dropped during HDR -> frame still completes the full 4096 reads.
